demux1_8_deser: RTL and testbench
=================================

# demux1_8_deser

Bit-serial to byte-parallel deserializer, the receive-side counterpart of the 8:1 bit-select mux used as a serializer. A 3-bit bit-index counter steers each incoming bit into one position of an 8-bit assembly register, acting as a 1:8 demux over time. Completed bytes move into a one-entry output holding register with a valid/ready handshake. It sits between a serial link front end and byte-wide consumers.

## Interface
- `LSB_FIRST`, default 1. 1: the first bit of a byte lands in bit 0. 0: the first bit lands in bit 7.
- `clk`  in  1  rising-edge clock for all state.
- `rst`  in  1  reset; synchronous, active-high.
- `bit_in`  in  1  serial data bit.
- `bit_valid`  in  1  `bit_in` is valid this cycle and is always accepted (no backpressure on the serial side).
- `sof`  in  1  start of frame, qualified by `bit_valid`. The current bit becomes bit index 0 of a new byte.
- `q`  out  8  assembled byte; stable while `q_valid`=1.
- `q_valid`  out  1  output holding register is full.
- `q_ready`  in  1  consumer accepts `q` when `q_valid` and `q_ready` are both 1 at a clock edge.
- `sel`  out  3  index of the next bit to be written (0..7).
- `busy`  out  1  partial byte in progress (`sel`!=0).
- `overrun`  out  1  sticky: a completed byte was dropped because the holding register was full.
- `clr_ovr`  in  1  clears `overrun` at the next clock edge.

## Operation
- Assembly register `asm[7:0]` and counter `sel`.
  - Accepted bit with `sof`=0: write `bit_in` into `asm[LSB_FIRST ? sel : 7-sel]`, then `sel` <= `sel`+1, wrapping 7 -> 0.
  - Accepted bit with `sof`=1: discard the partial byte, write the bit at index 0, set `sel` <= 1. Only the new bit survives; stale `asm` bits are don't-care because every position is rewritten before completion.
  - `sof` with `bit_valid`=0 is ignored.
- Byte completion: a bit is accepted while `sel`=7 (`sof`=0). The completed byte is `asm` with the final bit merged in.
- Output holding FSM, two states:
  - EMPTY (`q_valid`=0): on completion, `q` <= byte and go to FULL.
  - FULL (`q_valid`=1): on a handshake with no completion, go to EMPTY. On a handshake and a completion in the same cycle, load the new byte and stay FULL (no bubble). On a completion with no handshake, drop the new byte, set `overrun`<=1, keep `q` unchanged, and `sel` still wraps to 0.
- `overrun`: set on a drop, cleared by `clr_ovr`. If a set and a clear happen in the same cycle, the set wins.
- `busy` = (`sel` != 0), combinational from the register.

## Timing
- Reset values: `q`=8'h00, `q_valid`=0, `sel`=0, `busy`=0, `overrun`=0; `asm` cleared.
- `rst` overrides all inputs in that cycle. Reset mid-byte discards the partial byte and any held byte.
- Latency: `q_valid` rises on the edge at which the 8th bit is accepted. The byte is visible in the cycle after that bit is presented.
- Throughput: one bit per clock, one byte per 8 clocks sustained. With `q_ready` tied to 1, no overrun occurs at full rate.
- `q` and `q_valid` change only at clock edges. `q` does not change while `q_valid`=1 and `q_ready`=0, except through reset.
- `bit_valid` gaps of any length hold `sel` and `asm` unchanged.

## Test plan
- **Basic byte, LSB_FIRST=1:** reset, then 8 consecutive bits 1,0,1,1,0,0,1,0 with `q_ready`=1 -> `q`=8'h4D, `q_valid`=1 for exactly one cycle, `sel` back to 0, `overrun`=0.
- **MSB-first, LSB_FIRST=0:** same bit stream -> `q`=8'hB2.
- **Backpressure and overrun:** send byte 8'hA5 with `q_ready`=0, then a full second byte 8'h3C -> `q` stays 8'hA5 and `overrun`=1. Assert `q_ready` -> `q_valid` falls. Pulse `clr_ovr` -> `overrun`=0.
- **Back-to-back with same-cycle drain:** bytes 8'h01 and 8'hFF streamed continuously, with `q_ready` asserted exactly at the second completion -> `q_valid` stays 1 and `q` goes 8'h01 -> 8'hFF with no bubble and no overrun.
- **Resync:** 5 bits of garbage, then `sof`+`bit_valid` starting byte 8'h81 -> `q`=8'h81 after 8 more accepted bits, and the garbage bits never appear.
- **Reset mid-byte and bit gaps:** assert `rst` after 3 bits -> `sel`=0 and `busy`=0. Then send 8'h5A with random `bit_valid` gaps -> `q`=8'h5A.

Source files
------------

// File: rtl/demux1_8_deser.sv
// demux1_8_deser: serial-to-byte deserializer with a one-entry valid/ready output holding register
module demux1_8_deser #(
  parameter int LSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       sof,
  output logic [7:0] q,
  output logic       q_valid,
  input  logic       q_ready,
  output logic [2:0] sel,
  output logic       busy,
  output logic       overrun,
  input  logic       clr_ovr
);
  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;
  logic       state;
  logic [7:0] acc, acc_next;
  logic [2:0] idx, pos;
  logic       done, take;
  always_comb begin
    idx = sof ? 3'd0 : sel;
    pos = (LSB_FIRST != 0) ? idx : 3'd7 - idx;
    acc_next = acc;
    acc_next[pos] = bit_in;
    done = bit_valid && !sof && sel == 3'd7;
    take = state == FULL && q_ready;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      q       <= 8'h00;
      acc     <= 8'h00;
      sel     <= 3'd0;
      overrun <= 1'b0;
    end else begin
      if (bit_valid) begin
        acc <= acc_next;
        sel <= sof ? 3'd1 : sel + 3'd1;
      end
      if (done && (state == EMPTY || take)) begin
        q     <= acc_next;
        state <= FULL;
      end else if (take) begin
        state <= EMPTY;
      end
      // a drop in the same cycle as a clear leaves overrun set
      overrun <= (done && state == FULL && !take) ? 1'b1 : clr_ovr ? 1'b0 : overrun;
    end
  end
  assign q_valid = state == FULL;
  assign busy    = sel != 3'd0;
endmodule

// File: tb/tb_demux1_8_deser.sv
// tb_demux1_8_deser: directed checks of the deserializer in LSB-first and MSB-first builds
module tb_demux1_8_deser;
  logic clk = 0;
  logic rst, bit_in, bit_valid, sof, q_ready, clr_ovr;
  logic [7:0] q, q_m;
  logic q_valid, q_valid_m, busy, busy_m, overrun, overrun_m;
  logic [2:0] sel, sel_m;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  demux1_8_deser dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
    .q(q), .q_valid(q_valid), .q_ready(q_ready), .sel(sel), .busy(busy),
    .overrun(overrun), .clr_ovr(clr_ovr)
  );

  demux1_8_deser #(.LSB_FIRST(0)) dut_m (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
    .q(q_m), .q_valid(q_valid_m), .q_ready(q_ready), .sel(sel_m), .busy(busy_m),
    .overrun(overrun_m), .clr_ovr(clr_ovr)
  );

  task automatic idle();
    @(negedge clk);
    bit_valid = 0;
    sof = 0;
    clr_ovr = 0;
  endtask

  task automatic send_bit(input logic b, input logic s);
    @(negedge clk);
    bit_in = b;
    bit_valid = 1;
    sof = s;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i], 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    bit_valid = 0;
    sof = 0;
    clr_ovr = 0;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (q !== 8'h00 || q_valid !== 1'b0 || sel !== 3'd0 || busy !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got q=%h v=%b sel=%0d busy=%b ovr=%b, exp q=00 v=0 sel=0 busy=0 ovr=0", q, q_valid, sel, busy, overrun);
    end
  endtask

  task automatic test_basic_lsb();
    logic [7:0] stream;
    stream = 8'b0100_1101;
    q_ready = 1;
    send_byte(stream);
    n_checks++;
    if (sel !== 3'd7 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_sel_mid: got sel=%0d busy=%b, exp sel=7 busy=1", sel, busy);
    end
    idle();
    n_checks++;
    if (q_valid !== 1'b1 || q !== 8'h4D) begin
      n_fail++;
      $display("FAIL basic_q: got q=%h v=%b, exp q=4d v=1", q, q_valid);
    end
    n_checks++;
    if (sel !== 3'd0 || busy !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_sel_ovr: got sel=%0d busy=%b ovr=%b, exp 0 0 0", sel, busy, overrun);
    end
    idle();
    n_checks++;
    if (q_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_one_cycle: got v=%b, exp v=0", q_valid);
    end
  endtask

  task automatic test_msb_first();
    do_reset();
    q_ready = 1;
    send_byte(8'b0100_1101);
    idle();
    n_checks++;
    if (q_valid_m !== 1'b1 || q_m !== 8'hB2) begin
      n_fail++;
      $display("FAIL msb_q: got q=%h v=%b, exp q=b2 v=1", q_m, q_valid_m);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    q_ready = 0;
    send_byte(8'hA5);
    idle();
    n_checks++;
    if (q_valid !== 1'b1 || q !== 8'hA5) begin
      n_fail++;
      $display("FAIL ovr_first: got q=%h v=%b, exp q=a5 v=1", q, q_valid);
    end
    send_byte(8'h3C);
    idle();
    n_checks++;
    if (q !== 8'hA5 || q_valid !== 1'b1 || overrun !== 1'b1 || sel !== 3'd0) begin
      n_fail++;
      $display("FAIL ovr_drop: got q=%h v=%b ovr=%b sel=%0d, exp q=a5 v=1 ovr=1 sel=0", q, q_valid, overrun, sel);
    end
    @(negedge clk);
    q_ready = 1;
    @(negedge clk);
    n_checks++;
    if (q_valid !== 1'b0 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_drain: got v=%b ovr=%b, exp v=0 ovr=1", q_valid, overrun);
    end
    clr_ovr = 1;
    idle();
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_clear: got ovr=%b, exp 0", overrun);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] second;
    second = 8'hFF;
    do_reset();
    q_ready = 0;
    send_byte(8'h01);
    for (int i = 0; i < 8; i++) begin
      send_bit(second[i], 1'b0);
      q_ready = (i == 7);
      n_checks++;
      if (q_valid !== 1'b1 || q !== 8'h01) begin
        n_fail++;
        $display("FAIL b2b_hold_%0d: got q=%h v=%b, exp q=01 v=1", i, q, q_valid);
      end
    end
    idle();
    q_ready = 0;
    n_checks++;
    if (q_valid !== 1'b1 || q !== 8'hFF || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_swap: got q=%h v=%b ovr=%b, exp q=ff v=1 ovr=0", q, q_valid, overrun);
    end
    q_ready = 1;
    idle();
  endtask

  task automatic test_resync();
    logic [7:0] v;
    v = 8'h81;
    do_reset();
    q_ready = 1;
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    idle();
    n_checks++;
    if (sel !== 3'd5 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL resync_partial: got sel=%0d busy=%b, exp sel=5 busy=1", sel, busy);
    end
    send_bit(v[0], 1'b1);
    for (int i = 1; i < 8; i++) send_bit(v[i], 1'b0);
    idle();
    n_checks++;
    if (q_valid !== 1'b1 || q !== 8'h81) begin
      n_fail++;
      $display("FAIL resync_q: got q=%h v=%b, exp q=81 v=1", q, q_valid);
    end
    idle();
  endtask

  task automatic test_reset_mid_and_gaps();
    logic [7:0] v;
    v = 8'h5A;
    do_reset();
    q_ready = 1;
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    @(negedge clk);
    rst = 1;
    bit_valid = 0;
    @(negedge clk);
    rst = 0;
    n_checks++;
    if (sel !== 3'd0 || busy !== 1'b0 || q_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst: got sel=%0d busy=%b v=%b, exp 0 0 0", sel, busy, q_valid);
    end
    for (int i = 0; i < 8; i++) begin
      send_bit(v[i], 1'b0);
      repeat ($urandom_range(0, 3)) idle();
    end
    idle();
    n_checks++;
    if (sel !== 3'd0 || q_valid !== 1'b1 || q !== 8'h5A) begin
      n_fail++;
      $display("FAIL gaps_q: got q=%h v=%b sel=%0d, exp q=5a v=1 sel=0", q, q_valid, sel);
    end
  endtask

  initial begin
    rst = 1;
    bit_in = 0;
    bit_valid = 0;
    sof = 0;
    q_ready = 0;
    clr_ovr = 0;
    test_reset();
    test_basic_lsb();
    test_msb_first();
    test_overrun();
    test_back_to_back();
    test_resync();
    test_reset_mid_and_gaps();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
